// File: rtl/data_mem_pkg.sv
// Shared types and default sizing for the parametrised data memory.
package data_mem_pkg;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } dmem_state_e;

    localparam int DMEM_DATA_W_DFLT = 4;
    localparam int DMEM_DEPTH_DFLT  = 16;

endpackage

// File: rtl/dmem_parity.sv
// Even-parity generator (XOR reduce); used on both the write and read side of the data memory.
module dmem_parity
    import data_mem_pkg::*;
#(
    parameter int DATA_W = DMEM_DATA_W_DFLT
) (
    input  logic [DATA_W-1:0] data,
    output logic              parity
);

    assign parity = ^data;

endmodule

// File: rtl/data_memory_p.sv
// Parametrised synchronous data memory with post-reset address=data init and registered read.
// Optional per-word parity storage and checking is enabled by defining DMEM_PARITY_EN.
//
// state | meaning
// INIT  | sequencer writes mem[cnt] = cnt one word per cycle; requests ignored, busy=1
// READY | serve writes (priority) and registered reads until reset
module data_memory_p
    import data_mem_pkg::*;
#(
    parameter int DATA_W = DMEM_DATA_W_DFLT,
    parameter int DEPTH  = DMEM_DEPTH_DFLT,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_en,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] w_data,
`ifdef DMEM_PARITY_EN
    input  logic              inj_err,
`endif
    output logic [DATA_W-1:0] r_data,
    output logic              r_valid,
    output logic              busy,
    output logic              err
);

`ifdef DMEM_PARITY_EN
    localparam int WORD_W = DATA_W + 1;
`else
    localparam int WORD_W = DATA_W;
`endif
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    logic [WORD_W-1:0] mem [DEPTH];

    dmem_state_e       state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] r_data_q, r_data_d;
    logic              r_valid_q, r_valid_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [WORD_W-1:0] mem_word;
    logic [WORD_W-1:0] rd_word;
    logic              rd_par_bad;

    // Zero-extends or truncates the counter to a data word, whichever the widths need.
    logic [DATA_W+ADDR_W-1:0] cnt_ext;
    logic [DATA_W-1:0]        init_word;

    assign cnt_ext   = {{DATA_W{1'b0}}, cnt_q};
    assign init_word = cnt_ext[DATA_W-1:0];
    assign rd_word   = mem[addr];

`ifdef DMEM_PARITY_EN
    logic wr_par;
    logic rd_par;
    logic wr_flip;

    // Init writes always carry correct parity; only host writes may corrupt it.
    assign wr_flip = (state_q == READY) && inj_err;

    dmem_parity #(.DATA_W(DATA_W)) u_par_wr (
        .data   (mem_wdata),
        .parity (wr_par)
    );

    dmem_parity #(.DATA_W(DATA_W)) u_par_rd (
        .data   (rd_word[DATA_W-1:0]),
        .parity (rd_par)
    );

    assign mem_word   = {wr_par ^ wr_flip, mem_wdata};
    assign rd_par_bad = rd_par != rd_word[DATA_W];
`else
    assign mem_word   = mem_wdata;
    assign rd_par_bad = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        r_data_d  = r_data_q;
        r_valid_d = 1'b0;
        busy_d    = busy_q;
        err_d     = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = addr;
        mem_wdata = w_data;

        case (state_q)
            INIT: begin
                mem_we    = 1'b1;
                mem_waddr = cnt_q;
                mem_wdata = init_word;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == LAST_ADDR) begin
                    state_d = READY;
                    busy_d  = 1'b0;
                end
            end
            READY: begin
                if (wr_en) begin
                    mem_we = 1'b1;
                end else if (rd_en) begin
                    r_valid_d = 1'b1;
                    r_data_d  = rd_word[DATA_W-1:0];
                    err_d     = rd_par_bad;
                end
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= INIT;
            cnt_q     <= '0;
            r_data_q  <= '0;
            r_valid_q <= 1'b0;
            busy_q    <= 1'b1;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            r_data_q  <= r_data_d;
            r_valid_q <= r_valid_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
        end
    end

    // Array carries no reset; its contents are defined by the INIT sweep.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_word;
        end
    end

    assign r_data  = r_data_q;
    assign r_valid = r_valid_q;
    assign busy    = busy_q;
    assign err     = err_q;

endmodule

// File: tb/tb_data_memory_p.sv
// Self-checking bench for data_memory_p: directed scenarios plus a randomized run against an array model.
module tb_data_memory_p;

    localparam int DATA_W = 4;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              rd_en = 1'b0;
    logic              wr_en = 1'b0;
    logic [ADDR_W-1:0] addr = '0;
    logic [DATA_W-1:0] w_data = '0;
`ifdef DMEM_PARITY_EN
    logic              inj_err = 1'b0;
`endif
    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              busy;
    logic              err;

    int total = 0;
    int bad   = 0;

    // Reference: plain array of words plus the last value a read delivered.
    logic [DATA_W-1:0] model [DEPTH];
    logic [DATA_W-1:0] exp_data;

    data_memory_p #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .reset   (reset),
        .rd_en   (rd_en),
        .wr_en   (wr_en),
        .addr    (addr),
        .w_data  (w_data),
`ifdef DMEM_PARITY_EN
        .inj_err (inj_err),
`endif
        .r_data  (r_data),
        .r_valid (r_valid),
        .busy    (busy),
        .err     (err)
    );

    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic model_identity();
        for (int i = 0; i < DEPTH; i++) model[i] = DATA_W'(i);
        exp_data = '0;
    endtask

    task automatic test_reset();
        int n;
        reset = 1'b1; rd_en = 1'b0; wr_en = 1'b0;
        cycle(); cycle();
        total++; if (r_data !== '0)   begin bad++; $display("FAIL reset_r_data got=%h want=0", r_data); end
        total++; if (r_valid !== 1'b0) begin bad++; $display("FAIL reset_r_valid got=%b want=0", r_valid); end
        total++; if (busy !== 1'b1)    begin bad++; $display("FAIL reset_busy got=%b want=1", busy); end
        total++; if (err !== 1'b0)     begin bad++; $display("FAIL reset_err got=%b want=0", err); end
        reset = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            cycle();
            n++;
        end
        total++; if (n != DEPTH) begin bad++; $display("FAIL init_len got=%0d want=%0d", n, DEPTH); end
        model_identity();
    endtask

    task automatic test_init_pattern();
        for (int i = 0; i < DEPTH; i++) begin
            addr = ADDR_W'(i); rd_en = 1'b1;
            cycle();
            exp_data = model[i];
            total++; if (r_valid !== 1'b1 || r_data !== exp_data)
                begin bad++; $display("FAIL init_read[%0d] got=%h/%b want=%h/1", i, r_data, r_valid, exp_data); end
        end
        rd_en = 1'b0;
        cycle();
        total++; if (r_valid !== 1'b0 || r_data !== exp_data)
            begin bad++; $display("FAIL idle_hold got=%h/%b want=%h/0", r_data, r_valid, exp_data); end
    endtask

    task automatic test_write_read();
        wr_en = 1'b1; addr = 4'd5; w_data = 4'hA;
        cycle();
        model[5] = 4'hA;
        total++; if (r_valid !== 1'b0) begin bad++; $display("FAIL wr_valid got=%b want=0", r_valid); end
        wr_en = 1'b0; rd_en = 1'b1;
        cycle();
        exp_data = model[5];
        total++; if (r_valid !== 1'b1 || r_data !== 4'hA)
            begin bad++; $display("FAIL wr_then_rd got=%h/%b want=a/1", r_data, r_valid); end
        rd_en = 1'b0;
    endtask

    task automatic test_collision();
        rd_en = 1'b1; wr_en = 1'b1; addr = 4'd3; w_data = 4'h7;
        cycle();
        model[3] = 4'h7;
        total++; if (r_valid !== 1'b0 || r_data !== exp_data)
            begin bad++; $display("FAIL collide got=%h/%b want=%h/0", r_data, r_valid, exp_data); end
        wr_en = 1'b0;
        cycle();
        exp_data = model[3];
        total++; if (r_valid !== 1'b1 || r_data !== 4'h7)
            begin bad++; $display("FAIL collide_rd got=%h/%b want=7/1", r_data, r_valid); end
        rd_en = 1'b0;
    endtask

    task automatic test_init_ignore();
        int n;
        reset = 1'b1; cycle(); reset = 1'b0;
        wr_en = 1'b1; rd_en = 1'b1; addr = 4'd2; w_data = 4'hF;
        n = 0;
        while (n < 40) begin
            cycle();
            n++;
            total++; if (r_valid !== 1'b0) begin bad++; $display("FAIL init_rvalid cyc=%0d got=%b want=0", n, r_valid); end
            if (busy !== 1'b1) break;
        end
        wr_en = 1'b0; rd_en = 1'b0;
        total++; if (n != DEPTH) begin bad++; $display("FAIL init_ignore_len got=%0d want=%0d", n, DEPTH); end
        model_identity();
        rd_en = 1'b1; addr = 4'd2;
        cycle();
        exp_data = model[2];
        total++; if (r_valid !== 1'b1 || r_data !== 4'h2)
            begin bad++; $display("FAIL init_ignore_rd got=%h/%b want=2/1", r_data, r_valid); end
        rd_en = 1'b0;
    endtask

    task automatic test_mid_reset();
        int n;
        wr_en = 1'b1; addr = 4'd7; w_data = 4'hC;
        cycle();
        wr_en = 1'b0; rd_en = 1'b1;
        cycle();
        rd_en = 1'b0;
        total++; if (r_data !== 4'hC) begin bad++; $display("FAIL pre_reset_rd got=%h want=c", r_data); end
        reset = 1'b1;
        #1;
        total++; if (r_data !== '0 || r_valid !== 1'b0 || busy !== 1'b1)
            begin bad++; $display("FAIL ready_reset got=%h/%b/%b want=0/0/1", r_data, r_valid, busy); end
        cycle();
        reset = 1'b0;
        repeat (7) cycle();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_init_busy got=%b want=1", busy); end
        reset = 1'b1;
        #1;
        total++; if (r_data !== '0 || r_valid !== 1'b0 || busy !== 1'b1 || err !== 1'b0)
            begin bad++; $display("FAIL init_reset got=%h/%b/%b/%b want=0/0/1/0", r_data, r_valid, busy, err); end
        cycle();
        reset = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            cycle();
            n++;
        end
        total++; if (n != DEPTH) begin bad++; $display("FAIL restart_len got=%0d want=%0d", n, DEPTH); end
        model_identity();
        rd_en = 1'b1; addr = 4'd7;
        cycle();
        exp_data = model[7];
        total++; if (r_data !== 4'h7 || r_valid !== 1'b1)
            begin bad++; $display("FAIL restart_rd got=%h/%b want=7/1", r_data, r_valid); end
        rd_en = 1'b0;
    endtask

    task automatic test_random();
        logic              do_wr, do_rd, exp_valid;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        for (int k = 0; k < 300; k++) begin
            do_wr = ($urandom_range(0, 2) == 0);
            do_rd = ($urandom_range(0, 3) != 0);
            a     = ADDR_W'($urandom_range(0, DEPTH - 1));
            d     = DATA_W'($urandom);
            wr_en = do_wr; rd_en = do_rd; addr = a; w_data = d;
            cycle();
            exp_valid = 1'b0;
            if (do_wr) model[a] = d;
            else if (do_rd) begin
                exp_valid = 1'b1;
                exp_data  = model[a];
            end
            total++; if (r_valid !== exp_valid || r_data !== exp_data || err !== 1'b0)
                begin bad++; $display("FAIL rand[%0d] got=%h/%b/%b want=%h/%b/0", k, r_data, r_valid, err, exp_data, exp_valid); end
        end
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

`ifdef DMEM_PARITY_EN
    task automatic test_parity();
        wr_en = 1'b1; addr = 4'd9; w_data = 4'h3; inj_err = 1'b1;
        cycle();
        wr_en = 1'b0; inj_err = 1'b0; rd_en = 1'b1;
        cycle();
        total++; if (r_data !== 4'h3 || err !== 1'b1)
            begin bad++; $display("FAIL par_inj got=%h/%b want=3/1", r_data, err); end
        rd_en = 1'b0; wr_en = 1'b1;
        cycle();
        wr_en = 1'b0; rd_en = 1'b1;
        cycle();
        total++; if (r_data !== 4'h3 || err !== 1'b0)
            begin bad++; $display("FAIL par_clean got=%h/%b want=3/0", r_data, err); end
        rd_en = 1'b0;
        cycle();
        exp_data = 4'h3;
        model[9] = 4'h3;
    endtask
`endif

    initial begin
        test_reset();
        test_init_pattern();
        test_write_read();
        test_collision();
        test_init_ignore();
        test_mid_reset();
`ifdef DMEM_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_memory_p.md
# data_memory_p

Parametrised synchronous data memory for the simple processor datapath, successor to the fixed 16x4 data store. It adds configurable width and depth, a post-reset initialisation sequencer that loads an address-equals-data pattern one word per cycle, a registered read with a valid strobe, and optional per-word parity checking. It sits between the controller's D_rd/D_wr/D_addr signals and the register file write-back path.

## Interface
- DATA_W, 4, data word width in bits (>=1)
- DEPTH, 16, number of words (>=2, power of two)
- ADDR_W, $clog2(DEPTH), address width; derived, do not override
- clk  in  1  clock, rising-edge active
- reset  in  1  asynchronous, active-high reset
- rd_en  in  1  read request
- wr_en  in  1  write request
- addr  in  ADDR_W  word address
- w_data  in  DATA_W  write data
- inj_err  in  1  invert stored parity on this write (present only with DMEM_PARITY_EN)
- r_data  out  DATA_W  registered read data
- r_valid  out  1  one-cycle strobe: r_data updated by a read
- busy  out  1  initialisation in progress; requests ignored
- err  out  1  parity mismatch on the read reported by r_valid

## Operation
- Reset: r_data=0, r_valid=0, busy=1, err=0, state=INIT, init counter=0. Memory array has no reset; contents defined only by INIT.
- FSM states: INIT, READY.
- INIT: each cycle writes mem[cnt] = cnt[DATA_W-1:0] (zero-extended if ADDR_W<DATA_W, truncated otherwise), cnt++. When cnt==DEPTH-1 is written, next state READY, busy=0. rd_en/wr_en ignored in INIT; r_valid stays 0.
- READY, wr_en=1: mem[addr]<=w_data at clock edge. Write has priority: if rd_en also 1, read is dropped, r_valid=0.
- READY, rd_en=1, wr_en=0: r_data<=mem[addr], r_valid=1 next cycle.
- READY, neither: r_data holds, r_valid=0.
- Back-to-back reads: one per cycle, r_valid held high continuously.
- Read of an address written in the previous cycle returns the new data.
- Reset asserted mid-INIT or mid-READY: immediate return to reset values; INIT restarts from address 0 after deassertion.
- No terminal state; READY persists until reset.

## Timing
- INIT lasts exactly DEPTH cycles after the first rising edge with reset low; busy falls after the DEPTH-th edge.
- First request accepted on the first edge with busy=0.
- Read latency 1 cycle: request sampled at edge N, r_data/r_valid/err valid after edge N, for one cycle.
- Write visible to a read sampled at edge N+1.
- All outputs registered; no combinational input-to-output paths.

## Configuration
- DMEM_PARITY_EN defined: each word stores DATA_W+1 bits; extra bit = even parity of data (XOR reduce), inverted when inj_err=1 on the write. INIT writes correct parity. On read, err=1 with r_valid iff stored parity != recomputed parity; err=0 whenever r_valid=0. inj_err port exists.
- Undefined: no parity storage, inj_err port absent, err tied 0.

## Structure
- Package data_mem_pkg: state typedef enum {INIT, READY}; default DATA_W/DEPTH constants.
- One sub-module: dmem_parity (parameter DATA_W; data in, parity out), instantiated for write-side generation and read-side check; instantiated only under DMEM_PARITY_EN.

## Test plan
- Reset, release, count cycles -> busy=1 for exactly 16 edges, then 0; reads of addr 0..15 return 0x0..0xF with r_valid each cycle.
- wr_en=1, addr=5, w_data=0xA; next cycle rd_en addr=5 -> r_data=0xA, r_valid=1 one cycle later.
- rd_en=1 and wr_en=1, addr=3, w_data=0x7 -> r_valid=0, r_data unchanged; subsequent read of 3 returns 0x7.
- Requests during INIT (wr addr 2, 0xF) -> ignored; after busy=0, read addr 2 returns 0x2.
- Reset pulse mid-INIT at cnt=7 -> outputs to reset values, busy=1 for a full 16 cycles again.
- DMEM_PARITY_EN: write addr 9 data 0x3 with inj_err=1, read addr 9 -> r_data=0x3, err=1; rewrite without inj_err, read -> err=0. DATA_W=8, DEPTH=64 build: init pattern 0x00..0x3F.
